// File: rtl/lpif_dstrm_pkg.sv
// Shared types for the LPIF downstream receive buffer: flit layout and link-phase encoding.
package lpif_dstrm_pkg;

  localparam logic [3:0] LPIF_STATE_RESET = 4'h0;

  typedef struct packed {
    logic [3:0]   state;
    logic [1:0]   protid;
    logic [255:0] data;
    logic         dvalid;
    logic [15:0]  crc;
    logic         crc_valid;
  } dstrm_flit_t;

  typedef enum logic [1:0] {
    PH_OFFLINE = 2'd0,
    PH_SYNC    = 2'd1,
    PH_ACTIVE  = 2'd2,
    PH_DRAIN   = 2'd3
  } link_phase_e;

endpackage

// File: rtl/lpif_dstrm_fifo.sv
// Single-clock flit FIFO with synchronous flush; head entry is read combinationally and zeroed when empty.
module lpif_dstrm_fifo
  import lpif_dstrm_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  dstrm_flit_t                  wdata_i,
  output dstrm_flit_t                  rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  dstrm_flit_t      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign occ_o   = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Push at full is legal only with a simultaneous pop; the write then lands in the slot being freed.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/lpif_dstrm_rx_buffer.sv
// LPIF slave downstream receive buffer: link-phase FSM, FIFO, credit return and overflow tracking.
// Optional counters enabled by LPIF_DSTRM_STATS_EN.
module lpif_dstrm_rx_buffer
  import lpif_dstrm_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic           clk_wr,
  input  logic           rst_wr_n,
  input  logic           rx_online,
  input  logic [3:0]     dstrm_state,
  input  logic [1:0]     dstrm_protid,
  input  logic [255:0]   dstrm_data,
  input  logic           dstrm_dvalid,
  input  logic [15:0]    dstrm_crc,
  input  logic           dstrm_crc_valid,
  input  logic           dstrm_valid,
  output logic [279:0]   buf_flit,
  output logic           buf_valid,
  input  logic           buf_ready,
  output logic           buf_afull,
  output logic           credit_return,
  output logic           state_change,
  output logic           overflow_sticky,
  output logic [1:0]     link_phase,
  output logic [31:0]    flit_count,
  output logic [15:0]    drop_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] AFULL_TH = CW'(AFULL_LEVEL);

  link_phase_e   phase_q, phase_d;
  dstrm_flit_t   in_flit, head_flit;
  logic [CW-1:0] occ;
  logic          full, empty, pop, push_req, accepted, drop, flush, enter_offline;
  logic [3:0]    last_state_q;
  logic          credit_q, state_change_q, overflow_q;

  assign in_flit = '{state: dstrm_state, protid: dstrm_protid, data: dstrm_data,
                     dvalid: dstrm_dvalid, crc: dstrm_crc, crc_valid: dstrm_crc_valid};

  always_comb begin
    phase_d  = phase_q;
    push_req = 1'b0;
    unique case (phase_q)
      PH_OFFLINE: if (rx_online) phase_d = PH_SYNC;
      PH_SYNC: begin
        if (!rx_online) phase_d = PH_OFFLINE;
        else if (dstrm_valid && dstrm_state != LPIF_STATE_RESET) begin
          push_req = 1'b1;
          phase_d  = PH_ACTIVE;
        end
      end
      PH_ACTIVE: begin
        if (!rx_online) phase_d = PH_DRAIN;
        else push_req = dstrm_valid;
      end
      PH_DRAIN: if (occ == '0) phase_d = rx_online ? PH_SYNC : PH_OFFLINE;
      default: phase_d = PH_OFFLINE;
    endcase
  end

  assign enter_offline = (phase_q != PH_OFFLINE) && (phase_d == PH_OFFLINE);
  assign flush         = enter_offline;
  assign pop           = buf_valid && buf_ready;
  assign accepted      = push_req && (!full || pop);
  assign drop          = push_req && full && !pop;

  lpif_dstrm_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_wr),
    .rst_ni  (rst_wr_n),
    .flush_i (flush),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i (in_flit),
    .rdata_o (head_flit),
    .full_o  (full),
    .empty_o (empty),
    .occ_o   (occ)
  );

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      phase_q        <= PH_OFFLINE;
      last_state_q   <= LPIF_STATE_RESET;
      credit_q       <= 1'b0;
      state_change_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      credit_q       <= pop;
      state_change_q <= accepted && (dstrm_state != last_state_q);
      // Holding the reference at RESET while offline makes the first push after OFFLINE compare to 4'h0.
      if (phase_q == PH_OFFLINE) last_state_q <= LPIF_STATE_RESET;
      else if (accepted)         last_state_q <= dstrm_state;
      if (enter_offline) overflow_q <= 1'b0;
      else if (drop)     overflow_q <= 1'b1;
    end
  end

  assign buf_flit        = head_flit;
  assign buf_valid       = !empty;
  assign buf_afull       = (occ >= AFULL_TH);
  assign credit_return   = credit_q;
  assign state_change    = state_change_q;
  assign overflow_sticky = overflow_q;
  assign link_phase      = phase_q;

`ifdef LPIF_DSTRM_STATS_EN
  logic [31:0] flit_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      flit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accepted) flit_cnt_q <= flit_cnt_q + 1'b1;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign flit_count = flit_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign flit_count = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_lpif_dstrm_rx_buffer.sv
// Directed bench for lpif_dstrm_rx_buffer with a flit scoreboard; honours LPIF_DSTRM_STATS_EN.
module tb_lpif_dstrm_rx_buffer;
  import lpif_dstrm_pkg::*;

`ifdef LPIF_DSTRM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk_wr, rst_wr_n, rx_online;
  logic [3:0]   dstrm_state;
  logic [1:0]   dstrm_protid;
  logic [255:0] dstrm_data;
  logic         dstrm_dvalid, dstrm_crc_valid, dstrm_valid;
  logic [15:0]  dstrm_crc;
  logic [279:0] buf_flit;
  logic         buf_valid, buf_ready, buf_afull, credit_return, state_change, overflow_sticky;
  logic [1:0]   link_phase;
  logic [31:0]  flit_count;
  logic [15:0]  drop_count;

  lpif_dstrm_rx_buffer #(.DEPTH(16), .AFULL_LEVEL(12)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .buf_flit(buf_flit), .buf_valid(buf_valid),
    .buf_ready(buf_ready), .buf_afull(buf_afull), .credit_return(credit_return),
    .state_change(state_change), .overflow_sticky(overflow_sticky),
    .link_phase(link_phase), .flit_count(flit_count), .drop_count(drop_count)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  int unsigned tests_run = 0, tests_failed = 0;
  int unsigned credit_cnt = 0, sc_cnt = 0;
  dstrm_flit_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic send(input logic [3:0] st, input bit acc);
    dstrm_flit_t f;
    f.state = st;
    f.protid = 2'($urandom);
    for (int i = 0; i < 8; i++) f.data[i*32 +: 32] = $urandom;
    f.dvalid = 1'($urandom);
    f.crc = 16'($urandom);
    f.crc_valid = 1'($urandom);
    dstrm_state = f.state; dstrm_protid = f.protid; dstrm_data = f.data;
    dstrm_dvalid = f.dvalid; dstrm_crc = f.crc; dstrm_crc_valid = f.crc_valid;
    dstrm_valid = 1'b1;
    if (acc) exp_q.push_back(f);
    step();
    dstrm_valid = 1'b0;
  endtask

  // Output monitor: scoreboard pops, credit one cycle after each pop, head stability under stall.
  logic        prev_pop = 1'b0, prev_hold = 1'b0;
  logic [279:0] hold_flit;
  always @(negedge clk_wr) begin
    if (!rst_wr_n) begin
      prev_pop = 1'b0;
      prev_hold = 1'b0;
    end else begin
      tests_run++;
      assert (credit_return === prev_pop) else begin
        tests_failed++;
        $error("FAIL credit_return: observed %0b expected %0b", credit_return, prev_pop);
      end
      if (credit_return === 1'b1) credit_cnt++;
      if (state_change === 1'b1) sc_cnt++;
      if (prev_hold) begin
        tests_run++;
        assert (buf_flit === hold_flit) else begin
          tests_failed++;
          $error("FAIL head_stable: observed %h expected %h", buf_flit, hold_flit);
        end
      end
      if (buf_valid && buf_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $error("FAIL pop_unexpected: observed %h expected none", buf_flit);
        end else begin
          dstrm_flit_t e;
          e = exp_q.pop_front();
          assert (buf_flit === e) else begin
            tests_failed++;
            $error("FAIL pop_data: observed %h expected %h", buf_flit, e);
          end
        end
      end
      prev_pop  = buf_valid && buf_ready;
      prev_hold = buf_valid && !buf_ready;
      hold_flit = buf_flit;
    end
  end

  initial begin
    rst_wr_n = 1'b0; rx_online = 1'b0; buf_ready = 1'b0; dstrm_valid = 1'b0;
    dstrm_state = '0; dstrm_protid = '0; dstrm_data = '0; dstrm_dvalid = 1'b0;
    dstrm_crc = '0; dstrm_crc_valid = 1'b0;
    step(); step();
    chk("rst_phase", link_phase, 0);
    chk("rst_valid", buf_valid, 0);
    chk("rst_flit_zero", buf_flit == '0, 1);
    chk("rst_afull", buf_afull, 0);
    chk("rst_overflow", overflow_sticky, 0);
    chk("rst_credit", credit_return, 0);
    chk("rst_flit_count", flit_count, 0);
    chk("rst_drop_count", drop_count, 0);

    // 1: basic flow through SYNC into ACTIVE
    rst_wr_n = 1'b1; rx_online = 1'b1;
    step();
    chk("t1_sync", link_phase, PH_SYNC);
    buf_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(4'h1, 1'b1);
    chk("t1_active", link_phase, PH_ACTIVE);
    repeat (4) step();
    chk("t1_credits", credit_cnt, 5);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_state_change", sc_cnt, 1);

    // 2: overflow with consumer stalled
    buf_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(4'h1, k < 16);
      chk($sformatf("t2_afull_%0d", k + 1), buf_afull, (k + 1) >= 12);
    end
    chk("t2_overflow", overflow_sticky, 1);
    chk("t2_drop_count", drop_count, STATS ? 4 : 0);
    chk("t2_flit_count", flit_count, STATS ? 21 : 0);
    chk("t2_valid", buf_valid, 1);

    // 3: push+pop at full, then a plain push proves occupancy is still 16
    buf_ready = 1'b1;
    send(4'h1, 1'b1);
    buf_ready = 1'b0;
    chk("t3_drop_after_pp", drop_count, STATS ? 4 : 0);
    send(4'h1, 1'b0);
    chk("t3_drop_full", drop_count, STATS ? 5 : 0);
    chk("t3_afull", buf_afull, 1);
    buf_ready = 1'b1;
    repeat (20) step();
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_credits", credit_cnt, 22);
    chk("t3_valid", buf_valid, 0);

    // 4: back to SYNC via DRAIN/OFFLINE; state 0 flit ignored
    rx_online = 1'b0;
    step();
    chk("t4_drain", link_phase, PH_DRAIN);
    step();
    chk("t4_offline", link_phase, PH_OFFLINE);
    chk("t4_overflow_clr", overflow_sticky, 0);
    rx_online = 1'b1;
    step();
    chk("t4_sync", link_phase, PH_SYNC);
    sc_cnt = 0;
    send(4'h0, 1'b0);
    chk("t4_still_sync", link_phase, PH_SYNC);
    send(4'h1, 1'b1);
    chk("t4_active", link_phase, PH_ACTIVE);
    repeat (4) step();
    chk("t4_state_change", sc_cnt, 1);
    chk("t4_credits", credit_cnt, 23);
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: drain to OFFLINE, then drain with rx_online re-raised -> SYNC
    buf_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'h1, 1'b1);
    chk("t5_afull", buf_afull, 0);
    rx_online = 1'b0;
    send(4'h1, 1'b0);
    chk("t5_drain", link_phase, PH_DRAIN);
    buf_ready = 1'b1;
    repeat (12) step();
    chk("t5_offline", link_phase, PH_OFFLINE);
    chk("t5_credits", credit_cnt, 31);
    chk("t5_sb_empty", exp_q.size(), 0);
    rx_online = 1'b1;
    step();
    chk("t5_sync", link_phase, PH_SYNC);
    buf_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'h1, 1'b1);
    chk("t5_active", link_phase, PH_ACTIVE);
    rx_online = 1'b0;
    send(4'h1, 1'b0);
    chk("t5_drain2", link_phase, PH_DRAIN);
    rx_online = 1'b1; buf_ready = 1'b1;
    step();
    chk("t5_drain_hold", link_phase, PH_DRAIN);
    repeat (12) step();
    chk("t5_resync", link_phase, PH_SYNC);
    chk("t5_credits2", credit_cnt, 39);
    chk("t5_sb_empty2", exp_q.size(), 0);

    // 6: asynchronous reset with 6 flits buffered
    buf_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(4'h1, 1'b1);
    chk("t6_active", link_phase, PH_ACTIVE);
    chk("t6_flit_count", flit_count, STATS ? 45 : 0);
    chk("t6_valid_pre", buf_valid, 1);
    rst_wr_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_valid", buf_valid, 0);
    chk("t6_flit_zero", buf_flit == '0, 1);
    chk("t6_phase", link_phase, PH_OFFLINE);
    chk("t6_afull", buf_afull, 0);
    chk("t6_flit_count_clr", flit_count, 0);
    chk("t6_drop_count_clr", drop_count, 0);
    buf_ready = 1'b1;
    repeat (3) step();
    rst_wr_n = 1'b1; rx_online = 1'b0;
    repeat (3) step();
    chk("t6_no_credit", credit_cnt, 39);
    chk("t6_offline", link_phase, PH_OFFLINE);
    chk("t6_valid_post", buf_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
